// File: rtl/operand_loader.sv
// Operand entry front end for the sign-magnitude adder: synchronises and debounces
// the push button, then captures A and B from the slide switches on successive presses.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   LOAD_A | waiting for a press to capture operand A
//   LOAD_B | waiting for a press to capture operand B (raises ready)
//   SHOW   | both operands valid, adder result shown; press restarts entry
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       ready,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta_q, btn_meta_d;
    logic             btn_s_q, btn_s_d;
    logic [3:0]       sw_meta_q, sw_meta_d;
    logic [3:0]       sw_s_q, sw_s_d;
    logic             db_q, db_d;
    logic             db_dly_q, db_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic             ready_q, ready_d;
    logic             press;

    // Negative zero is folded to +0 so the adder never sees two encodings of zero.
    function automatic logic [3:0] norm(input logic [3:0] x);
        return (x == 4'b1000) ? 4'b0000 : x;
    endfunction

    always_comb begin
        btn_meta_d = btn;
        btn_s_d    = btn_meta_q;
        sw_meta_d  = sw;
        sw_s_d     = sw_meta_q;

        db_d  = db_q;
        cnt_d = cnt_q;
        if (btn_s_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = btn_s_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        db_dly_d = db_q;
        press    = db_q & ~db_dly_q;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ready_d = ready_q;
        case (state_q)
            LOAD_A: begin
                if (press) begin
                    a_d     = norm(sw_s_q);
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_d     = norm(sw_s_q);
                    ready_d = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    ready_d = 1'b0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            sw_meta_q  <= 4'b0000;
            sw_s_q     <= 4'b0000;
            db_q       <= 1'b0;
            db_dly_q   <= 1'b0;
            cnt_q      <= '0;
            state_q    <= LOAD_A;
            a_q        <= 4'b0000;
            b_q        <= 4'b0000;
            ready_q    <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_s_q    <= btn_s_d;
            sw_meta_q  <= sw_meta_d;
            sw_s_q     <= sw_s_d;
            db_q       <= db_d;
            db_dly_q   <= db_dly_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ready_q    <= ready_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign ready = ready_q;
    assign state = state_q;

endmodule

// File: doc/operand_loader.md
# operand_loader

Front-end operand entry stage for the 4-bit sign-magnitude adder. Captures two sign-magnitude operands from the board's four slide switches using a single push button, presents them on `a`/`b` for the adder, and flags when both operands are valid. The button is synchronised and debounced internally. A three-state sequencer steps the user through load A → load B → show result.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before the debounced button level changes (10 ms at 50 MHz); minimum 2.
- `CNT_W`, default 19: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `sw` in 4: raw switches, asynchronous; bit 3 = sign (1 = negative), bits 2:0 = magnitude.
- `btn` in 1: raw push button, asynchronous, active-high, bouncy.
- `a` out 4: operand A, sign-magnitude, registered.
- `b` out 4: operand B, sign-magnitude, registered.
- `ready` out 1: high while both operands are loaded and the adder result is meaningful.
- `state` out 2: current sequencer state, for LEDs (00 = LOAD_A, 01 = LOAD_B, 10 = SHOW).

## Operation
- **Synchronisers**
  - `btn` passes through a 2-FF synchroniser (`btn_s`).
  - `sw` passes through a 2-FF synchroniser per bit (`sw_s`).
- **Debounce**
  - Registered level `db` and counter `cnt`.
  - If `btn_s == db`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `db <= btn_s` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- **Press event**
  - `db_q` is `db` delayed one cycle.
  - `press = db & ~db_q`: exactly one cycle per debounced rising edge.
  - A release produces no event.
- **Normalisation**
  - `norm(x)` = 4'b0000 if `x == 4'b1000` (negative zero); otherwise `x`.
  - The magnitude is never altered.
- **Sequencer**, acting only on `press`:
  - **LOAD_A**: `a <= norm(sw_s)`; go to LOAD_B.
  - **LOAD_B**: `b <= norm(sw_s)`; `ready <= 1`; go to SHOW.
  - **SHOW**: `ready <= 0`; go to LOAD_A. `a` and `b` keep their values until overwritten.
  - Without `press`, all registers hold.
  - Unreachable encoding 11 returns to LOAD_A on the next edge, with `ready <= 0`.
- **Reset** (`rst_n` low at a rising edge) clears all of the following on that edge, regardless of state:
  - outputs: `a` = 0000, `b` = 0000, `ready` = 0, `state` = 00;
  - internal: `db` = 0, `db_q` = 0, `cnt` = 0, synchronisers = 0.
- Reset mid-debounce discards the pending count. A button still held when reset releases must first be debounced high; it then generates one press.

## Timing
- **Press latency**, for `btn` first sampled high at edge k and held:
  - `btn_s` = 1 after edge k+1.
  - `db` rises at edge k+1+DEBOUNCE_CYCLES.
  - `press` is high in the following cycle.
  - `a`/`b`/`ready`/`state` update at edge k+2+DEBOUNCE_CYCLES.
- **Glitch rejection**: any `btn_s` excursion shorter than DEBOUNCE_CYCLES consecutive cycles leaves `db` unchanged and resets `cnt`.
- **Switch sampling**: the switch value used is `sw_s` at the sequencer edge, i.e. the raw `sw` as of 2 edges earlier. Switches changing after that edge do not affect the captured operand.
- **Held button**: one press only. A second press requires `db` to fall (release stable for DEBOUNCE_CYCLES cycles) and then rise again.
- **Output stability**: all outputs are registered, glitch-free, and change only on the sequencer edge or the reset edge.
- **Downstream**: the adder is combinational, so its result is valid in the same cycle `ready` rises.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, CNT_W = 3.
1. **Reset**: `rst_n` = 0 for 2 cycles, then 1 → `a` = 0000, `b` = 0000, `ready` = 0, `state` = 00; these stay unchanged for 20 idle cycles.
2. **Full sequence**: `sw` = 0101, `btn` high 10 cycles from edge k → `a` = 0101 at edge k+6 and `state` = 01. Release 10 cycles, then `sw` = 1011 and press → `b` = 1011, `ready` = 1, `state` = 10.
3. **Bounce**: `btn` pattern 1,1,1,0,1,1,0 then low → no output changes, `db` stays 0. Then 1 held 6 cycles → exactly one press.
4. **Negative zero**: in LOAD_A, `sw` = 1000, press → `a` = 0000. In LOAD_B, `sw` = 1000, press → `b` = 0000, `ready` = 1.
5. **Wrap and hold**: in SHOW, press → `ready` = 0, `state` = 00, `a`/`b` retain 0101/1011. `btn` held 40 cycles → only one transition occurs.
6. **Mid-operation reset**: in LOAD_B, with `btn` 3 cycles into debounce, `rst_n` = 0 for 1 edge → all outputs cleared on that edge. With `btn` still held, exactly one press follows after release of reset + 6 edges, loading `a`.
